// File: rtl/inst_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// inst_sequencer_pkg
// Shared definitions for the instruction sequencer and its decoder:
//   - opcode encodings of the 8-bit instruction word (bits [7:6])
//   - ALU function encodings driven on alu_func
//   - write-data source encodings driven on wdata_sel
//   - sequencer state enumeration
//   - saturating increment helper for the 7-bit instruction counter
// ---------------------------------------------------------------------------
package inst_sequencer_pkg;

    // Opcode field, IR[7:6]
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    // ALU function field, IR[1:0] for ALU instructions
    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_AND = 2'b10;
    localparam logic [1:0] FUNC_NOT = 2'b11;

    // Register-file write-data source
    localparam logic [1:0] WSEL_IMM   = 2'b00;
    localparam logic [1:0] WSEL_PORTB = 2'b01;
    localparam logic [1:0] WSEL_ALU   = 2'b10;

    // Instruction counter saturates here; prog_len cannot exceed it
    localparam logic [6:0] COUNT_MAX = 7'd127;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STEP_H = 3'd1,
        S_STEP_L = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_EXEC_W = 3'd5,
        S_RETIRE = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    // Increment that sticks at COUNT_MAX instead of wrapping to zero
    function automatic logic [6:0] sat_inc(input logic [6:0] value);
        return (value == COUNT_MAX) ? value : value + 7'd1;
    endfunction

endpackage

// File: rtl/inst_sequencer_decode.sv
// ---------------------------------------------------------------------------
// inst_decode
// Purely combinational field extraction from an 8-bit instruction word.
// Kept separate so a disassembly monitor can reuse exactly the same view of
// the instruction format.
// Ports:
//   ir      in  8  instruction word
//   opcode  out 2  IR[7:6]
//   rd      out 2  destination register, IR[5:4]
//   rs      out 2  source register: IR[5:4] for STORE, IR[3:2] otherwise
//   imm     out 4  immediate, IR[3:0]
//   func    out 2  ALU function, IR[1:0]
// ---------------------------------------------------------------------------
module inst_decode
    import inst_sequencer_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic [3:0] imm,
    output logic [1:0] func
);

    // STORE names its single register in the Rd slot, so the source field
    // moves depending on the opcode; everything else is a fixed slice.
    always_comb begin
        opcode = ir[7:6];
        rd     = ir[5:4];
        imm    = ir[3:0];
        func   = ir[1:0];
        rs     = (ir[7:6] == OP_STORE) ? ir[5:4] : ir[3:2];
    end

endmodule

// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
// Consumer end of the instruction-ROM interface. Pulses step toward the ROM,
// captures the returned instruction, decodes it and issues one-shot control
// strobes to the 4-bit register file / ALU datapath. Runs prog_len
// instructions after start, then halts until clr.
// Parameters:
//   STEP_HIGH  cycles step is held high per fetch (>= 1)
//   STEP_LOW   cycles step is held low before inst is sampled (>= 1)
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   start, prog_len     begin program of prog_len instructions (IDLE only)
//   rom_done            ROM end-of-program indication
//   inst                instruction word from ROM
//   step                fetch strobe; each rising edge advances the ROM
//   busy, halted        running / finished status
//   seq_err             sticky: ROM ended before prog_len instructions ran
//   rf_we, rf_waddr     register-file write strobe and address
//   rf_raddr_a/b        read ports A and B
//   wdata_sel           write-data source (imm / port B / ALU)
//   imm, alu_func       immediate value and ALU function
//   store_en            store strobe for the register on port A
//   inst_count          instructions completed
// ---------------------------------------------------------------------------
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int STEP_HIGH = 2,
    parameter int STEP_LOW  = 2
)
(
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [6:0] prog_len,
    input  logic       rom_done,
    input  logic [7:0] inst,
    output logic       step,
    output logic       busy,
    output logic       halted,
    output logic       seq_err,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic [1:0] wdata_sel,
    output logic [3:0] imm,
    output logic [1:0] alu_func,
    output logic       store_en,
    output logic [6:0] inst_count
);

    localparam logic [7:0] STEP_H_LAST = 8'(STEP_HIGH - 1);
    localparam logic [7:0] STEP_L_LAST = 8'(STEP_LOW - 1);

    // Control state
    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] ir_q, ir_d;
    logic [6:0] len_q, len_d;
    logic [6:0] count_q, count_d;
    logic       abort_q, abort_d;
    logic       seq_err_q, seq_err_d;
    logic       running;

    // Registered outputs
    logic       step_q, step_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic       rf_we_q, rf_we_d;
    logic [1:0] rf_waddr_q, rf_waddr_d;
    logic [1:0] rf_raddr_a_q, rf_raddr_a_d;
    logic [1:0] rf_raddr_b_q, rf_raddr_b_d;
    logic [1:0] wdata_sel_q, wdata_sel_d;
    logic [3:0] imm_q, imm_d;
    logic [1:0] alu_func_q, alu_func_d;
    logic       store_en_q, store_en_d;

    // Decoded view of the IR value that will be held after this edge
    logic [1:0] dec_op;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs;
    logic [3:0] dec_imm;
    logic [1:0] dec_func;

    // The decoder looks at ir_d rather than ir_q so that the address fields
    // can be registered on the same edge that loads the IR, making them
    // visible from the DECODE cycle onward.
    inst_decode u_decode (
        .ir     (ir_d),
        .opcode (dec_op),
        .rd     (dec_rd),
        .rs     (dec_rs),
        .imm    (dec_imm),
        .func   (dec_func)
    );

    // Next-state logic. The fetch phases share one cycle counter which is
    // cleared on every phase change. The RETIRE decision is made after the
    // rom_done check so that an early end seen during RETIRE itself still
    // sends the sequencer to HALT instead of starting another fetch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ir_d      = ir_q;
        len_d     = len_q;
        count_d   = count_q;
        abort_d   = abort_q;
        seq_err_d = seq_err_q;
        running   = (state_q != S_IDLE) && (state_q != S_HALT);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = prog_len;
                    count_d = '0;
                    phase_d = '0;
                    state_d = (prog_len == 7'd0) ? S_HALT : S_STEP_H;
                end
            end
            S_STEP_H: begin
                if (phase_q == STEP_H_LAST) begin
                    phase_d = '0;
                    state_d = S_STEP_L;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_STEP_L: begin
                if (phase_q == STEP_L_LAST) begin
                    phase_d = '0;
                    ir_d    = inst;
                    state_d = S_DECODE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (dec_op == OP_ALU) ? S_EXEC_W : S_RETIRE;
            S_EXEC_W: state_d = S_RETIRE;
            S_RETIRE: count_d = sat_inc(count_q);
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // An end-of-program from the ROM is only an error if it arrives
        // before the final instruction retires.
        if (running && rom_done && (count_d < len_q)) begin
            seq_err_d = 1'b1;
            abort_d   = 1'b1;
        end

        if (state_q == S_RETIRE) begin
            state_d = ((count_d == len_q) || abort_d) ? S_HALT : S_STEP_H;
        end
    end

    // Output logic, computed from the state being entered so every output
    // can come straight from a flop yet line up with its state. Field
    // outputs follow the IR, so they stay put from DECODE until the next
    // instruction is loaded.
    always_comb begin
        step_d       = (state_d == S_STEP_H);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d     = (state_d == S_HALT);
        rf_we_d      = 1'b0;
        store_en_d   = 1'b0;
        rf_waddr_d   = '0;
        rf_raddr_a_d = '0;
        rf_raddr_b_d = '0;
        wdata_sel_d  = WSEL_IMM;
        imm_d        = '0;
        alu_func_d   = FUNC_ADD;

        unique case (dec_op)
            OP_LOAD: begin
                rf_waddr_d  = dec_rd;
                wdata_sel_d = WSEL_IMM;
                imm_d       = dec_imm;
                rf_we_d     = (state_d == S_EXEC);
            end
            OP_STORE: begin
                rf_raddr_a_d = dec_rs;
                store_en_d   = (state_d == S_EXEC);
            end
            OP_MOVE: begin
                rf_waddr_d   = dec_rd;
                rf_raddr_b_d = dec_rs;
                wdata_sel_d  = WSEL_PORTB;
                rf_we_d      = (state_d == S_EXEC);
            end
            OP_ALU: begin
                rf_waddr_d   = dec_rd;
                rf_raddr_a_d = dec_rd;
                rf_raddr_b_d = dec_rs;
                wdata_sel_d  = WSEL_ALU;
                alu_func_d   = dec_func;
                rf_we_d      = (state_d == S_EXEC_W);
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers. clr drops step and every strobe on the
    // same edge, wherever the sequencer happened to be.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            ir_q         <= '0;
            len_q        <= '0;
            count_q      <= '0;
            abort_q      <= 1'b0;
            seq_err_q    <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_raddr_a_q <= '0;
            rf_raddr_b_q <= '0;
            wdata_sel_q  <= '0;
            imm_q        <= '0;
            alu_func_q   <= '0;
            store_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ir_q         <= ir_d;
            len_q        <= len_d;
            count_q      <= count_d;
            abort_q      <= abort_d;
            seq_err_q    <= seq_err_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_raddr_a_q <= rf_raddr_a_d;
            rf_raddr_b_q <= rf_raddr_b_d;
            wdata_sel_q  <= wdata_sel_d;
            imm_q        <= imm_d;
            alu_func_q   <= alu_func_d;
            store_en_q   <= store_en_d;
        end
    end

    assign step       = step_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign seq_err    = seq_err_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_raddr_a = rf_raddr_a_q;
    assign rf_raddr_b = rf_raddr_b_q;
    assign wdata_sel  = wdata_sel_q;
    assign imm        = imm_q;
    assign alu_func   = alu_func_q;
    assign store_en   = store_en_q;
    assign inst_count = count_q;

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Consumer end of the instruction-ROM interface.
- Generates the `step` strobe toward the program ROM, captures the returned 8-bit instruction, decodes it, and issues one-shot control strobes to the 4-bit register file / ALU datapath.
- Runs a program of `prog_len` instructions after `start`, then halts.
- Sits between the program ROM and the datapath control inputs.

Parameters:
- STEP_HIGH, 2, cycles `step` is held high per fetch (min 1).
- STEP_LOW, 2, cycles `step` is held low after the high phase before `inst` is sampled (min 1).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- start  in  1  begin program; honoured only in IDLE
- prog_len  in  7  number of instructions to run; sampled on accepted start
- rom_done  in  1  ROM end-of-program indication
- inst  in  8  instruction word from ROM
- step  out  1  fetch strobe to ROM; each rising edge advances the ROM by one
- busy  out  1  high in any state other than IDLE/HALT
- halted  out  1  high in HALT
- seq_err  out  1  sticky; set if rom_done is seen before prog_len instructions complete
- rf_we  out  1  register-file write strobe, 1 cycle
- rf_waddr  out  2  write register
- rf_raddr_a  out  2  read port A (Rd)
- rf_raddr_b  out  2  read port B (Rs)
- wdata_sel  out  2  write-data source: 00 imm, 01 port B, 10 ALU
- imm  out  4  immediate field
- alu_func  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT (of A)
- store_en  out  1  store strobe for the register on port A, 1 cycle
- inst_count  out  7  instructions completed

Behaviour:
- Reset (clr=1 at a clk edge, from any state):
  - state IDLE; all outputs 0, including step, seq_err and inst_count.
  - The IR register is cleared.
- Instruction decode (IR bit ranges):
  - [7:6] opcode.
  - LOAD 00: Rd=[5:4], imm=[3:0].
  - STORE 01: Rs=[5:4].
  - MOVE 10: Rd=[5:4], Rs=[3:2].
  - ALU 11: Rd=[5:4], Rs=[3:2], func=[1:0].
  - Example: 8'hD8 = ADD R1,R2; 8'hF3 = NOT R3.
  - 8'h00 is a valid LOAD R0,0 and is not an end marker.
- States and transitions:
  - IDLE: on start, latch prog_len. If prog_len==0, go to HALT, else STEP_H.
  - STEP_H: step=1 for STEP_HIGH cycles, then STEP_L.
  - STEP_L: step=0 for STEP_LOW cycles. On the last cycle, register inst into IR, then DECODE.
  - DECODE: drive the address fields from IR; no strobes. Go to EXEC.
  - EXEC:
    - LOAD: rf_we=1, rf_waddr=Rd, wdata_sel=00.
    - STORE: store_en=1, rf_raddr_a=Rs.
    - MOVE: rf_we=1, rf_waddr=Rd, rf_raddr_b=Rs, wdata_sel=01.
    - ALU: no strobe; raddr_a=Rd, raddr_b=Rs and alu_func held; go to EXEC_W.
    - Non-ALU: go to RETIRE.
  - EXEC_W (ALU only): rf_we=1, rf_waddr=Rd, wdata_sel=10, with operands and func still held. Go to RETIRE.
  - RETIRE: inst_count+=1. If new count==latched prog_len, go to HALT, else STEP_H.
  - HALT: halted=1, holds until clr; start is ignored.
- Outputs are registered. Strobes (rf_we, store_en) are high for exactly one cycle per instruction. Address and function fields stay stable from DECODE through the cycle after the strobe.
- Latency per instruction: STEP_HIGH+STEP_LOW+3 cycles for non-ALU, +4 for ALU (7 and 8 cycles at defaults).
- rom_done:
  - Sampled every cycle while busy.
  - If high while inst_count<prog_len: set seq_err, finish the current instruction, then go to HALT.
  - Ignored in IDLE and HALT.
- inst_count saturates at 127; prog_len ≤ 127 by width.
- start while busy: ignored, no effect on the latched prog_len.
- clr mid-fetch: step drops to 0 on the same edge. The ROM is not reset by this block; the ROM's clr is driven from the same clr net.

Decomposition:
- Shared package:
  - opcode constants (OP_LOAD, OP_STORE, OP_MOVE, OP_ALU)
  - ALU func constants
  - wdata_sel encodings
  - state enum
- Natural sub-module: inst_decode, purely combinational: IR → opcode, Rd, Rs, imm, func. It is shared later with a disassembly monitor in the bench.

Test Plan:
- clr, then start with prog_len=1 and inst=8'h23: step pulses once. EXEC cycle shows rf_we=1, rf_waddr=2, imm=3, wdata_sel=00. Then halted=1, inst_count=1, 7 cycles from start to RETIRE.
- ALU 8'hD9 (SUB R1,R2): EXEC shows raddr_a=1, raddr_b=2, alu_func=01, rf_we=0. Next cycle rf_we=1, wdata_sel=10, rf_waddr=1.
- Program 8'h36, 8'h70, 8'h98, prog_len=3: one store_en pulse with raddr_a=3. MOVE gives rf_waddr=1, raddr_b=2, wdata_sel=01. Exactly 3 rising edges of step.
- prog_len=0 start: immediate HALT, step never rises, inst_count=0.
- rom_done asserted during the 2nd of prog_len=5: seq_err=1, HALT after inst_count=2.
- clr asserted mid-STEP_H: next cycle step=0, IDLE, all outputs 0. A new start runs normally.
